// File: rtl/shift_frame_engine.sv
// Frame-level PISO/SIPO engine with valid/ready parallel sides, paced by the shft_en bit strobe.
// Optional macro SHIFT_PARITY_EN appends (TX) or checks and strips (RX) an even-parity bit per frame.
module shift_frame_engine #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mode,
   input  logic             dir,
   input  logic             shft_en,
   input  logic             se_in,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             se_out,
   output logic             se_out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             frame_done,
   output logic             busy,
   output logic             overrun,
   input  logic             overrun_clr,
   output logic             parity_err
);

`ifdef SHIFT_PARITY_EN
   localparam int FRAME_BITS = WIDTH + 1;
`else
   localparam int FRAME_BITS = WIDTH;
`endif
   localparam int CNT_W = $clog2(FRAME_BITS + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BITS - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      TX_SHIFT = 2'd1,
      RX_SHIFT = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   sreg_q, sreg_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               dir_q, dir_d;
   logic               se_out_q, se_out_d;
   logic               se_out_valid_q, se_out_valid_d;
   logic [WIDTH-1:0]   out_data_q, out_data_d;
   logic               out_valid_q, out_valid_d;
   logic               frame_done_q, frame_done_d;
   logic               overrun_q, overrun_d;
   logic               deliver;
   logic               rx_dir;
   logic [WIDTH-1:0]   rx_shift;
`ifdef SHIFT_PARITY_EN
   localparam logic [CNT_W-1:0] PAR_CNT = CNT_W'(WIDTH);
   logic               parity_q, parity_d;
   logic               parity_err_q, parity_err_d;
`endif

   // Handshakes: a parallel word moves on any cycle where valid && ready are both high;
   // the engine holds out_valid/out_data stable until out_ready accepts them.
   assign in_ready     = (state_q == IDLE) && !mode;
   assign busy         = (state_q != IDLE);
   assign se_out       = se_out_q;
   assign se_out_valid = se_out_valid_q;
   assign out_data     = out_data_q;
   assign out_valid    = out_valid_q;
   assign frame_done   = frame_done_q;
   assign overrun      = overrun_q;
`ifdef SHIFT_PARITY_EN
   assign parity_err   = parity_err_q;
`else
   assign parity_err   = 1'b0;
`endif

   // The first RX bit is shifted in from IDLE, where dir is taken straight from the pin.
   assign rx_dir   = (state_q == IDLE) ? dir : dir_q;
   assign rx_shift = rx_dir ? {sreg_q[WIDTH-2:0], se_in} : {se_in, sreg_q[WIDTH-1:1]};

   always_comb begin
      state_d        = state_q;
      sreg_d         = sreg_q;
      cnt_d          = cnt_q;
      dir_d          = dir_q;
      se_out_d       = se_out_q;
      se_out_valid_d = 1'b0;
      out_data_d     = out_data_q;
      out_valid_d    = out_valid_q;
      frame_done_d   = 1'b0;
      overrun_d      = overrun_q;
      deliver        = 1'b0;
`ifdef SHIFT_PARITY_EN
      parity_d       = parity_q;
      parity_err_d   = 1'b0;
`endif

      case (state_q)
         IDLE: begin
            if (!mode) begin
               if (in_valid) begin
                  sreg_d  = in_data;
                  dir_d   = dir;
                  cnt_d   = '0;
                  state_d = TX_SHIFT;
`ifdef SHIFT_PARITY_EN
                  parity_d = ^in_data;
`endif
               end
            end else if (shft_en) begin
               dir_d   = dir;
               sreg_d  = rx_shift;
               cnt_d   = CNT_ONE;
               state_d = RX_SHIFT;
            end
         end
         TX_SHIFT: begin
            if (shft_en) begin
               se_out_d = dir_q ? sreg_q[WIDTH-1] : sreg_q[0];
`ifdef SHIFT_PARITY_EN
               if (cnt_q == PAR_CNT) se_out_d = parity_q;
`endif
               sreg_d         = dir_q ? {sreg_q[WIDTH-2:0], 1'b0} : {1'b0, sreg_q[WIDTH-1:1]};
               se_out_valid_d = 1'b1;
               cnt_d          = cnt_q + CNT_ONE;
               if (cnt_q == LAST_CNT) begin
                  state_d      = IDLE;
                  frame_done_d = 1'b1;
               end
            end
         end
         RX_SHIFT: begin
            if (shft_en) begin
               cnt_d = cnt_q + CNT_ONE;
`ifdef SHIFT_PARITY_EN
               // The trailing parity bit is compared, not shifted, so sreg keeps the data word.
               if (cnt_q == PAR_CNT) parity_err_d = (se_in != ^sreg_q);
               else                  sreg_d       = rx_shift;
`else
               sreg_d = rx_shift;
`endif
               if (cnt_q == LAST_CNT) begin
                  state_d      = IDLE;
                  frame_done_d = 1'b1;
                  deliver      = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (overrun_clr) overrun_d = 1'b0;
      if (deliver) begin
         if (!out_valid_q || out_ready) begin
            out_data_d  = sreg_d;
            out_valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= IDLE;
         sreg_q         <= '0;
         cnt_q          <= '0;
         dir_q          <= 1'b0;
         se_out_q       <= 1'b0;
         se_out_valid_q <= 1'b0;
         out_data_q     <= '0;
         out_valid_q    <= 1'b0;
         frame_done_q   <= 1'b0;
         overrun_q      <= 1'b0;
`ifdef SHIFT_PARITY_EN
         parity_q       <= 1'b0;
         parity_err_q   <= 1'b0;
`endif
      end else begin
         state_q        <= state_d;
         sreg_q         <= sreg_d;
         cnt_q          <= cnt_d;
         dir_q          <= dir_d;
         se_out_q       <= se_out_d;
         se_out_valid_q <= se_out_valid_d;
         out_data_q     <= out_data_d;
         out_valid_q    <= out_valid_d;
         frame_done_q   <= frame_done_d;
         overrun_q      <= overrun_d;
`ifdef SHIFT_PARITY_EN
         parity_q       <= parity_d;
         parity_err_q   <= parity_err_d;
`endif
      end
   end

endmodule

// File: tb/tb_shift_frame_engine.sv
// Bench for shift_frame_engine: directed frames from the test plan plus randomized TX/RX
// frames checked against a bit-order model and an expected-word queue.
module tb_shift_frame_engine;

   localparam int W = 8;
`ifdef SHIFT_PARITY_EN
   localparam int FB = W + 1;
`else
   localparam int FB = W;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         mode, dir, shft_en, se_in, in_valid, out_ready, overrun_clr;
   logic [W-1:0] in_data;
   logic         in_ready, se_out, se_out_valid, out_valid, frame_done, busy, overrun, parity_err;
   logic [W-1:0] out_data;

   int           errors = 0;
   int           checks = 0;
   logic [W-1:0] exp_q[$];
   logic         m_overrun = 1'b0;

   shift_frame_engine #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .mode(mode), .dir(dir), .shft_en(shft_en), .se_in(se_in),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .se_out(se_out), .se_out_valid(se_out_valid),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .frame_done(frame_done), .busy(busy), .overrun(overrun),
      .overrun_clr(overrun_clr), .parity_err(parity_err)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached, errors=%0d", errors);
      $fatal(1, "bench timeout");
   end

   // Wire order of a frame: bit i is the i-th bit on the serial line.
   function automatic logic [FB-1:0] wire_bits(input logic [W-1:0] w, input logic d, input logic bad_par);
      logic [FB-1:0] b;
      b = '0;
      for (int i = 0; i < W; i++) b[i] = d ? w[W-1-i] : w[i];
`ifdef SHIFT_PARITY_EN
      b[W] = (^w) ^ bad_par;
`else
      if (bad_par) b = b;
`endif
      return b;
   endfunction

   task automatic test_reset();
      rst = 1'b1; mode = 1'b0; dir = 1'b0; shft_en = 1'b0; se_in = 1'b0; in_valid = 1'b0;
      out_ready = 1'b0; overrun_clr = 1'b0; in_data = '0;
      #3;
      checks++; if (se_out !== 1'b0)       begin errors++; $display("FAIL rst_se_out: got %b want 0", se_out); end
      checks++; if (se_out_valid !== 1'b0) begin errors++; $display("FAIL rst_se_out_valid: got %b want 0", se_out_valid); end
      checks++; if (out_data !== '0)       begin errors++; $display("FAIL rst_out_data: got %h want 0", out_data); end
      checks++; if (out_valid !== 1'b0)    begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
      checks++; if (frame_done !== 1'b0)   begin errors++; $display("FAIL rst_frame_done: got %b want 0", frame_done); end
      checks++; if (overrun !== 1'b0)      begin errors++; $display("FAIL rst_overrun: got %b want 0", overrun); end
      checks++; if (parity_err !== 1'b0)   begin errors++; $display("FAIL rst_parity_err: got %b want 0", parity_err); end
      checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
      @(posedge clk); #1 rst = 1'b0;
      checks++; if (in_ready !== 1'b1)     begin errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
   endtask

   task automatic tx_frame(input logic [W-1:0] data, input logic d, input int gap);
      logic eb;
      mode = 1'b0; #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL tx_in_ready_idle: got %b want 1", in_ready); end
      dir = d; in_data = data; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; dir = ~d; in_data = W'($urandom);
      checks++; if (busy !== 1'b1)       begin errors++; $display("FAIL tx_busy_start: got %b want 1", busy); end
      checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL tx_done_start: got %b want 0", frame_done); end
      for (int i = 0; i < FB; i++) begin
         eb = (i < W) ? (d ? data[W-1-i] : data[i]) : ^data;
         shft_en = 1'b1;
         @(posedge clk); #1;
         shft_en = 1'b0;
         checks++; if (se_out !== eb) begin errors++; $display("FAIL tx_bit%0d: data %h dir %b got %b want %b", i, data, d, se_out, eb); end
         checks++; if (se_out_valid !== 1'b1) begin errors++; $display("FAIL tx_se_out_valid%0d: got %b want 1", i, se_out_valid); end
         checks++; if (frame_done !== (i == FB-1)) begin errors++; $display("FAIL tx_frame_done%0d: got %b want %b", i, frame_done, i == FB-1); end
         checks++; if (in_ready !== (i == FB-1)) begin errors++; $display("FAIL tx_in_ready%0d: got %b want %b", i, in_ready, i == FB-1); end
         if (i < FB-1) begin
            for (int g = 1; g < gap; g++) begin
               @(posedge clk); #1;
               checks++; if (se_out !== eb || se_out_valid !== 1'b0) begin errors++; $display("FAIL tx_hold%0d: se_out %b valid %b want %b 0", i, se_out, se_out_valid, eb); end
            end
         end
      end
   endtask

   task automatic rx_frame(input logic [FB-1:0] bits, input logic d, input int gap,
                           input logic rdy_at_end, input logic clr_at_end);
      logic [W-1:0] w;
      logic         perr;
      w = '0;
      for (int i = 0; i < W; i++) begin
         if (d) w[W-1-i] = bits[i];
         else   w[i]     = bits[i];
      end
      perr = 1'b0;
`ifdef SHIFT_PARITY_EN
      perr = (bits[W] != ^w);
`endif
      mode = 1'b1; dir = d;
      for (int i = 0; i < FB; i++) begin
         se_in = bits[i];
         if (i == FB-1) begin out_ready = rdy_at_end; overrun_clr = clr_at_end; end
         shft_en = 1'b1;
         @(posedge clk); #1;
         shft_en = 1'b0; out_ready = 1'b0; overrun_clr = 1'b0; dir = ~d; se_in = 1'($urandom);
         checks++; if (frame_done !== (i == FB-1)) begin errors++; $display("FAIL rx_frame_done%0d: got %b want %b", i, frame_done, i == FB-1); end
         checks++; if (busy !== (i != FB-1) || in_ready !== 1'b0) begin errors++; $display("FAIL rx_busy%0d: busy %b in_ready %b", i, busy, in_ready); end
         if (i < FB-1) begin
            for (int g = 1; g < gap; g++) @(posedge clk);
            #1;
         end
      end
      if (exp_q.size() == 0) exp_q.push_back(w);
      else if (rdy_at_end) begin void'(exp_q.pop_front()); exp_q.push_back(w); end
      else m_overrun = 1'b1;
      if (clr_at_end && !(exp_q.size() != 0 && !rdy_at_end && exp_q[0] !== w && 1'b0)) begin
         if (!(exp_q.size() == 1 && exp_q[0] !== w) || rdy_at_end) m_overrun = m_overrun;
      end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rx_out_valid: got %b want 1", out_valid); end
      checks++; if (out_data !== exp_q[0]) begin errors++; $display("FAIL rx_out_data: got %h want %h", out_data, exp_q[0]); end
      checks++; if (overrun !== m_overrun) begin errors++; $display("FAIL rx_overrun: got %b want %b", overrun, m_overrun); end
      checks++; if (parity_err !== perr) begin errors++; $display("FAIL rx_parity_err: got %b want %b", parity_err, perr); end
   endtask

   task automatic accept_word();
      checks++; if (out_valid !== 1'b1 || out_data !== exp_q[0]) begin errors++; $display("FAIL acc_before: valid %b data %h want 1 %h", out_valid, out_data, exp_q[0]); end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      void'(exp_q.pop_front());
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL acc_out_valid: got %b want 0", out_valid); end
      checks++; if (frame_done !== 1'b0 || parity_err !== 1'b0) begin errors++; $display("FAIL acc_pulses: done %b perr %b want 0 0", frame_done, parity_err); end
   endtask

   task automatic test_tx_directed();
      tx_frame(8'hC1, 1'b0, 1);
      tx_frame(8'hC1, 1'b1, 1);
      tx_frame(8'hC1, 1'b1, 3);
   endtask

   task automatic test_rx_directed();
      logic [FB-1:0] b;
      b = wire_bits(8'h83, 1'b0, 1'b0);
      rx_frame(b, 1'b1, 1, 1'b0, 1'b0);
      checks++; if (out_data !== 8'hC1) begin errors++; $display("FAIL rx_c1: got %h want c1", out_data); end
      repeat (3) @(posedge clk);
      #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rx_valid_hold: got %b want 1", out_valid); end
      accept_word();
      rx_frame(b, 1'b0, 2, 1'b0, 1'b0);
      checks++; if (out_data !== 8'h83) begin errors++; $display("FAIL rx_83: got %h want 83", out_data); end
      accept_word();
   endtask

   task automatic test_overrun();
      rx_frame(wire_bits(8'hC1, 1'b1, 1'b0), 1'b1, 1, 1'b0, 1'b0);
      rx_frame(wire_bits(8'h55, 1'b1, 1'b0), 1'b1, 1, 1'b0, 1'b0);
      checks++; if (out_data !== 8'hC1 || overrun !== 1'b1) begin errors++; $display("FAIL ovr_keep: data %h ovr %b want c1 1", out_data, overrun); end
      overrun_clr = 1'b1;
      @(posedge clk); #1;
      overrun_clr = 1'b0; m_overrun = 1'b0;
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clr: got %b want 0", overrun); end
      rx_frame(wire_bits(8'h3C, 1'b1, 1'b0), 1'b1, 1, 1'b1, 1'b0);
      checks++; if (out_data !== 8'h3C || overrun !== 1'b0) begin errors++; $display("FAIL ovr_same_cycle: data %h ovr %b want 3c 0", out_data, overrun); end
      // Drop a word while clearing: the new overrun must win.
      rx_frame(wire_bits(8'h9A, 1'b0, 1'b0), 1'b0, 1, 1'b0, 1'b1);
      checks++; if (overrun !== 1'b1 || out_data !== 8'h3C) begin errors++; $display("FAIL ovr_clr_race: ovr %b data %h want 1 3c", overrun, out_data); end
      accept_word();
      overrun_clr = 1'b1;
      @(posedge clk); #1;
      overrun_clr = 1'b0; m_overrun = 1'b0;
   endtask

   task automatic test_reset_mid_frame();
      mode = 1'b0; dir = 1'b0; in_data = 8'hA5; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         shft_en = 1'b1; @(posedge clk); #1; shft_en = 1'b0;
      end
      rst = 1'b1; #1;
      checks++; if (se_out !== 1'b0 || se_out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_tx: se_out %b valid %b busy %b want 0 0 0", se_out, se_out_valid, busy); end
      checks++; if (out_valid !== 1'b0 || out_data !== '0 || overrun !== 1'b0) begin errors++; $display("FAIL midrst_rx: valid %b data %h ovr %b want 0 0 0", out_valid, out_data, overrun); end
      @(posedge clk); #1 rst = 1'b0;
      exp_q.delete(); m_overrun = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks++; if (frame_done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_no_done%0d: done %b busy %b want 0 0", i, frame_done, busy); end
      end
      tx_frame(8'hFF, 1'b0, 1);
   endtask

   task automatic test_back_to_back();
      tx_frame(8'h5A, 1'b1, 1);
      tx_frame(8'h0F, 1'b0, 1);
      tx_frame(8'hE7, 1'b1, 2);
   endtask

   task automatic test_random();
      logic [W-1:0] w;
      logic         d;
      for (int n = 0; n < 16; n++) begin
         w = W'($urandom);
         d = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 1) == 1) begin
            tx_frame(w, d, $urandom_range(1, 3));
         end else begin
            rx_frame(wire_bits(w, d, 1'($urandom_range(0, 1))), d, $urandom_range(1, 3), 1'b0, 1'b0);
            checks++; if (out_data !== w) begin errors++; $display("FAIL rand_rx_word: got %h want %h", out_data, w); end
            accept_word();
         end
      end
   endtask

`ifdef SHIFT_PARITY_EN
   task automatic test_parity();
      tx_frame(8'h07, 1'b0, 1);
      checks++; if (se_out !== 1'b1) begin errors++; $display("FAIL par_tx_bit9: got %b want 1", se_out); end
      rx_frame(wire_bits(8'h07, 1'b0, 1'b1), 1'b0, 1, 1'b0, 1'b0);
      checks++; if (out_data !== 8'h07 || parity_err !== 1'b1) begin errors++; $display("FAIL par_rx: data %h perr %b want 07 1", out_data, parity_err); end
      accept_word();
   endtask
`endif

   initial begin
      test_reset();
      test_tx_directed();
      test_rx_directed();
      test_overrun();
      test_reset_mid_frame();
      test_back_to_back();
      test_random();
`ifdef SHIFT_PARITY_EN
      test_parity();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
